eq_band_scheduler: RTL and testbench
====================================

# eq_band_scheduler

Time-multiplexed controller for the 5-band FIR audio equalizer. It shares one multiply-accumulate datapath across every band and tap, replacing the five parallel FIR instances. Per accepted audio sample it:
- updates a sample history;
- walks each band's coefficient set from an external synchronous coefficient ROM;
- scales and saturates each band result, applies the per-band gain, and sums the bands;
- emits one equalized output sample with a valid pulse.

## Interface
Parameters:
- NUM_BANDS, 5, number of bands processed per sample
- ORDER_FIR, 64, taps per band
- INPUT_WIDTH, 24, signed audio sample width
- COEFF_WIDTH, 32, signed coefficient width
- COEFF_FRAC, 31, fractional bits of coefficients
- GAIN_WIDTH, 4, unsigned per-band gain width
- ACC_WIDTH, INPUT_WIDTH+COEFF_WIDTH+$clog2(ORDER_FIR), MAC accumulator width
- OUTPUT_WIDTH, INPUT_WIDTH+GAIN_WIDTH+3, signed output width

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_sample_valid  in  1  upstream sample present
- i_sample  in  INPUT_WIDTH  signed audio sample
- o_sample_ready  out  1  block can accept a sample this cycle
- i_gain  in  NUM_BANDS*GAIN_WIDTH  band b gain at bits [b*GAIN_WIDTH +: GAIN_WIDTH]
- o_coeff_addr  out  $clog2(NUM_BANDS*ORDER_FIR)  ROM address = band*ORDER_FIR + tap
- o_coeff_rd  out  1  ROM read strobe
- i_coeff  in  COEFF_WIDTH  ROM data, valid exactly 1 cycle after o_coeff_rd
- o_data_audio  out  OUTPUT_WIDTH  signed equalized sample
- o_data_valid  out  1  one-cycle pulse, o_data_audio valid
- o_busy  out  1  computation in progress

## Operation
- History: ORDER_FIR x INPUT_WIDTH register array, circular, with write pointer wr_ptr.
  - Tap k reads x[n-k], where x[n] is the sample just accepted.
  - Entries never written read as 0.
- State machine: IDLE -> LOAD -> MAC -> DRAIN -> BAND_END -> (MAC for the next band | DONE) -> IDLE.
- IDLE:
  - o_sample_ready=1.
  - When i_sample_valid=1, accept the sample: latch i_sample and all of i_gain, go to LOAD.
  - i_gain changes after acceptance have no effect on the current sample.
- LOAD: write the sample at wr_ptr; clear band index, tap counter, accumulator and band sum.
- MAC (ORDER_FIR cycles per band):
  - Issue o_coeff_rd=1 and the address for tap 0..ORDER_FIR-1.
  - One cycle later, acc += i_coeff * x[n-tap], full-precision signed product.
- DRAIN (1 cycle): accumulates the last tap; no read issued.
- BAND_END (1 cycle):
  - band_out = acc >>> COEFF_FRAC, arithmetic shift, truncation toward -inf.
  - Saturate band_out to signed INPUT_WIDTH range [-2^23, 2^23-1].
  - sum += band_out * gain[b], with gain zero-extended, i.e. treated as unsigned.
  - Clear acc, increment band; if band==NUM_BANDS-1, go to DONE.
- DONE:
  - o_data_audio <= sum; o_data_valid=1 for this cycle only.
  - wr_ptr <= wr_ptr+1, wrapping at ORDER_FIR-1 -> 0.
  - Go to IDLE.
- Sum width: OUTPUT_WIDTH holds NUM_BANDS*(2^23)*(2^GAIN_WIDTH-1) with margin, so no saturation is applied on the sum.
- o_busy = (state != IDLE); o_sample_ready = (state == IDLE).
- Accumulator wrap: acc is wide enough for ORDER_FIR full-scale products and is never saturated.

## Timing
- Reset values (asynchronous): o_data_audio=0, o_data_valid=0, o_coeff_rd=0, o_coeff_addr=0, o_busy=0, o_sample_ready=1 (state IDLE). History and wr_ptr are cleared to 0.
- Latency: o_data_valid is high in cycle A + NUM_BANDS*(ORDER_FIR+2) + 2, where A is the accepting edge. Default = 332 cycles.
- Throughput: one sample per NUM_BANDS*(ORDER_FIR+2)+3 cycles. Default = 333 cycles; the next sample can be accepted in the cycle after DONE.
- Handshake:
  - A transfer occurs only when i_sample_valid and o_sample_ready are both 1 at the same edge.
  - While o_busy=1, ready=0; upstream must hold its data, and no sample is dropped or overwritten.
- ROM: exactly one read per tap; addresses are strictly sequential within a band.
- Reset mid-operation aborts the computation immediately:
  - No o_data_valid is issued.
  - History returns to zero.
  - The first post-reset sample behaves as the first sample ever.
- i_sample_valid asserted in the same cycle as DONE is not accepted; it is accepted in the following IDLE cycle.

## Test plan
- Reset: assert i_reset_n=0 mid-MAC -> all outputs at reset values next cycle, no valid pulse; the next accepted sample yields the same result as from power-up.
- Impulse:
  - Setup: ROM band0 tap0 = 0x4000_0000 (0.5), all other coefficients 0; gains {9,8,7,6,5}.
  - Stimulus: sample 1000, then zeros.
  - Required: first output 4500 at cycle A+332; subsequent outputs 0.
- Delay line: band1 tap3 = 0x7FFF_FFFF, gain1 = 1; samples 10,20,30,40 -> 4th output = 9, i.e. floor(10*(2^31-1)/2^31).
- Saturation: band0 all taps 0x7FFF_FFFF, gain 15, constant input 0x7FFFFF -> band0 saturates to 8388607; output 125829105.
- Handshake: hold i_sample_valid=1 continuously with an incrementing sample -> one acceptance every 333 cycles, no skipped or duplicated sample values, ready=0 whenever busy.
- Gain latching: change i_gain from 9 to 0 one cycle after acceptance -> output still uses gain 9; the next sample uses 0 (band contribution 0).

Source files
------------

// File: rtl/eq_band_scheduler.sv
// Time-multiplexed 5-band FIR equalizer controller: one shared MAC walks every
// band's taps from an external synchronous coefficient ROM, then gains and sums bands.
module eq_band_scheduler #(
  parameter int NUM_BANDS    = 5,
  parameter int ORDER_FIR    = 64,
  parameter int INPUT_WIDTH  = 24,
  parameter int COEFF_WIDTH  = 32,
  parameter int COEFF_FRAC   = 31,
  parameter int GAIN_WIDTH   = 4,
  parameter int ACC_WIDTH    = INPUT_WIDTH + COEFF_WIDTH + $clog2(ORDER_FIR),
  parameter int OUTPUT_WIDTH = INPUT_WIDTH + GAIN_WIDTH + 3
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_sample_valid,
  input  logic signed [INPUT_WIDTH-1:0]         i_sample,
  output logic                                  o_sample_ready,
  input  logic [NUM_BANDS*GAIN_WIDTH-1:0]       i_gain,
  output logic [$clog2(NUM_BANDS*ORDER_FIR)-1:0] o_coeff_addr,
  output logic                                  o_coeff_rd,
  input  logic signed [COEFF_WIDTH-1:0]         i_coeff,
  output logic signed [OUTPUT_WIDTH-1:0]        o_data_audio,
  output logic                                  o_data_valid,
  output logic                                  o_busy
);

  localparam int TAP_W    = (ORDER_FIR > 1) ? $clog2(ORDER_FIR) : 1;
  localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int ADDR_W   = $clog2(NUM_BANDS*ORDER_FIR);
  localparam int PROD_W   = INPUT_WIDTH + COEFF_WIDTH;
  localparam int SCALED_W = INPUT_WIDTH + GAIN_WIDTH + 1;

  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(ORDER_FIR - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

  localparam logic signed [ACC_WIDTH-1:0] BAND_MAX =
    {{(ACC_WIDTH-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] BAND_MIN =
    {{(ACC_WIDTH-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_BAND_END,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TAP_W-1:0]  tap_cnt;
  logic [BAND_W-1:0] band_idx;
  logic [TAP_W-1:0]  wr_ptr;
  logic signed [INPUT_WIDTH-1:0] hist [ORDER_FIR];

  logic signed [INPUT_WIDTH-1:0]      sample_q;
  logic [NUM_BANDS*GAIN_WIDTH-1:0]    gain_q;
  logic signed [INPUT_WIDTH-1:0]      hist_p0;
  logic                               vld_p0;
  logic signed [PROD_W-1:0]           prod;
  logic signed [ACC_WIDTH-1:0]        acc;
  logic signed [OUTPUT_WIDTH-1:0]     sum;
  logic signed [INPUT_WIDTH-1:0]      band_sat;
  logic [GAIN_WIDTH-1:0]              gain_sel;
  logic signed [SCALED_W-1:0]         scaled;
  logic signed [OUTPUT_WIDTH-1:0]     sum_nxt;

  // Position of x[n-k] in the circular history, where x[n] sits at the write pointer.
  function automatic logic [TAP_W-1:0] hist_idx(input logic [TAP_W-1:0] p,
                                                input logic [TAP_W-1:0] k);
    logic [TAP_W:0] d;
    if (k <= p) d = {1'b0, p} - {1'b0, k};
    else        d = {1'b0, p} + (TAP_W+1)'(ORDER_FIR) - {1'b0, k};
    return d[TAP_W-1:0];
  endfunction

  // Drop coefficient fraction (floor) and clamp to the sample range.
  function automatic logic signed [INPUT_WIDTH-1:0] sat_band(
    input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = a >>> COEFF_FRAC;
    if (sh > BAND_MAX)      return BAND_MAX[INPUT_WIDTH-1:0];
    else if (sh < BAND_MIN) return BAND_MIN[INPUT_WIDTH-1:0];
    else                    return sh[INPUT_WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_sample_valid) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_MAC;
      S_MAC:      if (tap_cnt == TAP_LAST) state_nxt = S_DRAIN;
      S_DRAIN:    state_nxt = S_BAND_END;
      S_BAND_END: state_nxt = (band_idx == BAND_LAST) ? S_DONE : S_MAC;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign o_sample_ready = (state == S_IDLE);
  assign o_busy         = (state != S_IDLE);
  assign o_coeff_rd     = (state == S_MAC);
  assign o_coeff_addr   = ADDR_W'(int'(band_idx) * ORDER_FIR + int'(tap_cnt));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tap_cnt      <= '0;
      band_idx     <= '0;
      wr_ptr       <= '0;
      vld_p0       <= 1'b0;
      o_data_valid <= 1'b0;
      o_data_audio <= '0;
      for (int i = 0; i < ORDER_FIR; i++) hist[i] <= '0;
    end else begin
      o_data_valid <= 1'b0;
      vld_p0       <= (state == S_MAC);
      case (state)
        S_LOAD: begin
          hist[wr_ptr] <= sample_q;
          tap_cnt      <= '0;
          band_idx     <= '0;
        end
        S_MAC: tap_cnt <= (tap_cnt == TAP_LAST) ? '0 : tap_cnt + TAP_W'(1);
        S_BAND_END: begin
          if (band_idx == BAND_LAST) begin
            o_data_audio <= sum_nxt;
            o_data_valid <= 1'b1;
          end else begin
            band_idx <= band_idx + BAND_W'(1);
          end
        end
        S_DONE: wr_ptr <= (wr_ptr == TAP_LAST) ? '0 : wr_ptr + TAP_W'(1);
        default: ;
      endcase
    end
  end

  // Stage p0: history operand registered alongside the ROM read it pairs with.
  assign prod = PROD_W'(i_coeff) * PROD_W'(hist_p0);

  // Band end: scale, saturate and weight by the latched gain.
  always_comb begin
    band_sat = sat_band(acc);
    gain_sel = gain_q[int'(band_idx)*GAIN_WIDTH +: GAIN_WIDTH];
    scaled   = SCALED_W'(band_sat) * SCALED_W'($signed({1'b0, gain_sel}));
    sum_nxt  = sum + OUTPUT_WIDTH'(scaled);
  end

  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_sample_valid) begin
      sample_q <= i_sample;
      gain_q   <= i_gain;
    end
    hist_p0 <= hist[hist_idx(wr_ptr, tap_cnt)];
    if (state == S_LOAD) begin
      acc <= '0;
      sum <= '0;
    end else if (state == S_BAND_END) begin
      acc <= '0;
      sum <= sum_nxt;
    end else if (vld_p0) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: directed and random samples against a
// plain-arithmetic FIR/gain model, with a synchronous ROM and read monitor.
module tb_eq_band_scheduler;

  localparam int NB  = 5;
  localparam int ORD = 64;
  localparam int NCO = NB * ORD;

  logic               i_clk;
  logic               i_reset_n;
  logic               i_sample_valid;
  logic signed [23:0] i_sample;
  logic               o_sample_ready;
  logic [19:0]        i_gain;
  logic [8:0]         o_coeff_addr;
  logic               o_coeff_rd;
  logic signed [31:0] i_coeff;
  logic signed [30:0] o_data_audio;
  logic               o_data_valid;
  logic               o_busy;

  eq_band_scheduler dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_sample_ready (o_sample_ready),
    .i_gain         (i_gain),
    .o_coeff_addr   (o_coeff_addr),
    .o_coeff_rd     (o_coeff_rd),
    .i_coeff        (i_coeff),
    .o_data_audio   (o_data_audio),
    .o_data_valid   (o_data_valid),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int rom [NCO];
  int hist_q [$];
  int rom_err  = 0;
  int rd_count = 0;
  int exp_addr = 0;

  // Synchronous ROM: data one cycle after the read strobe, junk otherwise.
  always @(posedge i_clk) begin
    if (o_coeff_rd) i_coeff <= rom[o_coeff_addr];
    else            i_coeff <= $urandom;
  end

  // Every run must read addresses 0..NCO-1 in order.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exp_addr <= 0;
    end else if (o_coeff_rd) begin
      if (int'(o_coeff_addr) != exp_addr) rom_err <= rom_err + 1;
      exp_addr <= (exp_addr == NCO - 1) ? 0 : exp_addr + 1;
      rd_count <= rd_count + 1;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direct FIR per band over the most recent samples (newest first).
  function automatic longint model_out(input logic [19:0] g);
    longint sum, acc, band;
    int x;
    sum = 0;
    for (int b = 0; b < NB; b++) begin
      acc = 0;
      for (int k = 0; k < ORD; k++) begin
        x = (k < hist_q.size()) ? hist_q[k] : 0;
        acc += longint'(rom[b*ORD + k]) * longint'(x);
      end
      band = acc >>> 31;
      if (band > 64'sd8388607)       band = 64'sd8388607;
      else if (band < -64'sd8388608) band = -64'sd8388608;
      sum += band * longint'(g[b*4 +: 4]);
    end
    return sum;
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < NCO; i++) rom[i] = 0;
  endtask

  task automatic rom_random();
    for (int i = 0; i < NCO; i++) rom[i] = int'($urandom);
  endtask

  // Offer one sample, follow it to its output pulse and check the transaction.
  task automatic send(input logic signed [23:0] s, input logic [19:0] g,
                      input logic [19:0] g_after, input bit keep,
                      output longint t_acc, output longint dout);
    int waitc, lat, rd0, err0;
    bit proto_ok;
    longint exp;
    i_sample       = s;
    i_gain         = g;
    i_sample_valid = 1'b1;
    waitc = 0;
    while (!o_sample_ready && waitc < 400) begin
      @(negedge i_clk);
      waitc++;
    end
    check("accept_wait", longint'(o_sample_ready), 1);
    rd0  = rd_count;
    err0 = rom_err;
    @(posedge i_clk);
    t_acc = $time;
    hist_q.push_front(int'(s));
    if (hist_q.size() > ORD) void'(hist_q.pop_back());
    exp = model_out(g);
    @(negedge i_clk);
    i_gain = g_after;
    if (!keep) i_sample_valid = 1'b0;
    lat = 1;
    proto_ok = 1'b1;
    while (!o_data_valid && lat < 400) begin
      if (o_sample_ready || !o_busy) proto_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    dout = longint'(o_data_audio);
    check("latency", lat, 332);
    check("data", dout, exp);
    check("busy_ready", longint'(proto_ok), 1);
    check("rom_reads", rd_count - rd0, NCO);
    check("rom_addr_seq", rom_err - err0, 0);
    @(negedge i_clk);
    check("valid_pulse", longint'(o_data_valid), 0);
    check("ready_after", longint'(o_sample_ready), 1);
  endtask

  initial begin
    longint t, tprev, d;
    logic [19:0] g;
    logic signed [23:0] rs;
    int seen;

    i_reset_n      = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = '0;
    i_gain         = '0;
    rom_clear();
    repeat (2) @(negedge i_clk);
    check("rst_data", longint'(o_data_audio), 0);
    check("rst_valid", longint'(o_data_valid), 0);
    check("rst_rd", longint'(o_coeff_rd), 0);
    check("rst_addr", longint'(o_coeff_addr), 0);
    check("rst_busy", longint'(o_busy), 0);
    check("rst_ready", longint'(o_sample_ready), 1);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Impulse through band0 tap0 (0.5) with gain 9
    rom[0] = 32'h4000_0000;
    send(24'sd1000, 20'h56789, 20'h56789, 1'b0, t, d);
    check("impulse_first", d, 4500);
    send(24'sd0, 20'h56789, 20'h56789, 1'b0, t, d);
    check("impulse_tail1", d, 0);
    send(24'sd0, 20'h56789, 20'h56789, 1'b0, t, d);
    check("impulse_tail2", d, 0);

    // Delay line: band1 tap3 near unity
    rom_clear();
    rom[ORD + 3] = 32'h7FFF_FFFF;
    send(24'sd10, 20'h00010, 20'h00010, 1'b0, t, d);
    send(24'sd20, 20'h00010, 20'h00010, 1'b0, t, d);
    send(24'sd30, 20'h00010, 20'h00010, 1'b0, t, d);
    send(24'sd40, 20'h00010, 20'h00010, 1'b0, t, d);
    check("delay_line", d, 9);

    // Saturation: full-scale band0, gain 15
    rom_clear();
    for (int i = 0; i < ORD; i++) rom[i] = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) send(24'h7FFFFF, 20'h0000F, 20'h0000F, 1'b0, t, d);
    check("saturation", d, 125829105);

    // Gain latched at acceptance
    rom_clear();
    rom[0] = 32'h4000_0000;
    send(24'sd2000, 20'h00009, 20'h00000, 1'b0, t, d);
    check("gain_latched", d, 9000);
    send(24'sd2000, 20'h00000, 20'h00000, 1'b0, t, d);
    check("gain_zero", d, 0);

    // Back-to-back: valid held high with incrementing samples
    rom_random();
    g = 20'($urandom);
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      send(24'(100 + i), g, g, (i < 4), t, d);
      if (i > 0) check("accept_spacing", (t - tprev) / 10, 333);
      tprev = t;
    end

    // Random samples, gains and coefficients, long enough to wrap the history
    for (int i = 0; i < 70; i++) begin
      if (i % 20 == 0) rom_random();
      rs = 24'($urandom);
      g  = 20'($urandom);
      send(rs, g, 20'($urandom), 1'b0, t, d);
    end

    // Reset in the middle of a band's MAC walk
    i_sample       = 24'sd777;
    i_gain         = 20'hFFFFF;
    i_sample_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_sample_valid = 1'b0;
    repeat (100) @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    check("midrst_data", longint'(o_data_audio), 0);
    check("midrst_valid", longint'(o_data_valid), 0);
    check("midrst_rd", longint'(o_coeff_rd), 0);
    check("midrst_addr", longint'(o_coeff_addr), 0);
    check("midrst_busy", longint'(o_busy), 0);
    check("midrst_ready", longint'(o_sample_ready), 1);
    hist_q.delete();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    seen = 0;
    repeat (400) begin
      @(negedge i_clk);
      if (o_data_valid) seen++;
    end
    check("no_valid_after_reset", seen, 0);
    for (int i = 0; i < 3; i++) begin
      rs = 24'($urandom);
      g  = 20'($urandom);
      send(rs, g, g, 1'b0, t, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
